// File: rtl/parallel_to_serial.sv
`default_nettype none
// ============================================================================
// Module   : parallel_to_serial
// Purpose  : Loads a parallel word and shifts it out MSB first, one bit per
//            SER_EN && SHIFT_EN transfer. Define P2S_PARITY_EN to append an
//            even-parity bit after DATA[0].
// Revision : 1.0 - initial release
// ============================================================================
module parallel_to_serial #(
    parameter int data_size = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [data_size-1:0] DATA,
    input  logic                 LOAD,
    output logic                 READY,
    input  logic                 SHIFT_EN,
    output logic                 SER_DATA,
    output logic                 SER_EN,
    output logic                 DONE
);

    localparam int CNT_W = $clog2(data_size + 2);
`ifdef P2S_PARITY_EN
    localparam int FRAME_LEN_I = data_size + 1;
`else
    localparam int FRAME_LEN_I = data_size;
`endif
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_LEN_I);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [data_size-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 done_q,  done_d;
    logic                 last_bit;
`ifdef P2S_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign last_bit = (cnt_q == CNT_ONE);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
`ifdef P2S_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
`ifdef P2S_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
`ifdef P2S_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (LOAD) begin
                    shreg_d  = DATA;
                    cnt_d    = FRAME_LEN;
                    state_d  = S_SHIFT;
`ifdef P2S_PARITY_EN
                    parity_d = ^DATA;
`endif
                end
            end
            S_SHIFT: begin
                // A deasserted SHIFT_EN stalls the frame with every register held.
                if (SHIFT_EN) begin
                    shreg_d = {shreg_q[data_size-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_ONE;
                    if (last_bit) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        READY    = (state_q == S_IDLE);
        SER_EN   = (state_q == S_SHIFT);
        DONE     = done_q;
        SER_DATA = 1'b0;
        if (state_q == S_SHIFT) begin
            SER_DATA = shreg_q[data_size-1];
`ifdef P2S_PARITY_EN
            if (last_bit) begin
                SER_DATA = parity_q;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel_to_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_parallel_to_serial
// Purpose  : Self-checking bench for parallel_to_serial with data_size = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parallel_to_serial;

    localparam int W = 8;
`ifdef P2S_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] DATA;
    logic         LOAD;
    logic         READY;
    logic         SHIFT_EN;
    logic         SER_DATA;
    logic         SER_EN;
    logic         DONE;

    int total = 0;
    int bad   = 0;

    parallel_to_serial #(.data_size(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DATA     (DATA),
        .LOAD     (LOAD),
        .READY    (READY),
        .SHIFT_EN (SHIFT_EN),
        .SER_DATA (SER_DATA),
        .SER_EN   (SER_EN),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] exp_bits;
        logic         exp_par;
        int           stall_at;
        int           busy_at;
    } vec_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_check();
        LOAD     = 1'b0;
        SHIFT_EN = 1'($urandom_range(1, 0));
        tick();
        check("idle_done", DONE, 1'b0);
        check("idle_ready", READY, 1'b1);
        check("idle_ser_en", SER_EN, 1'b0);
    endtask

    // Sends one frame; the expected serial sequence is exp_bits MSB first,
    // then exp_par when parity is configured. busy_at = -2 means random busy loads.
    task automatic send_frame(input logic [W-1:0] data, input logic [W-1:0] exp_bits,
                              input logic exp_par, input int stall_pct, input int stall_at,
                              input int busy_at, input int abort_at);
        logic         seq [FL];
        logic [W-1:0] rx;
        logic         se;
        logic         sbit;
        int           idx;
        int           cyc;
        int           stalls;
        for (int k = 0; k < FL; k++) seq[k] = (k < W) ? exp_bits[W-1-k] : exp_par;
        check("load_ready", READY, 1'b1);
        DATA     = data;
        LOAD     = 1'b1;
        SHIFT_EN = 1'($urandom_range(1, 0));
        tick();
        LOAD   = 1'b0;
        DATA   = W'($urandom);
        idx    = 0;
        cyc    = 0;
        stalls = 3;
        rx     = '0;
        while (idx < FL) begin
            check("ser_en", SER_EN, 1'b1);
            check("busy_ready", READY, 1'b0);
            check("busy_done", DONE, 1'b0);
            check("ser_bit", SER_DATA, seq[idx]);
            if (idx == abort_at) begin
                RST  = 1'b0;
                LOAD = 1'b1;
                SHIFT_EN = 1'b1;
                tick();
                check("abort_ser_en", SER_EN, 1'b0);
                check("abort_ser_data", SER_DATA, 1'b0);
                check("abort_ready", READY, 1'b1);
                check("abort_done", DONE, 1'b0);
                RST  = 1'b1;
                LOAD = 1'b0;
                tick();
                check("post_abort_ser_en", SER_EN, 1'b0);
                check("post_abort_done", DONE, 1'b0);
                return;
            end
            se = 1'b1;
            if (idx == stall_at && stalls > 0) begin
                se = 1'b0;
                stalls--;
            end else if (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) begin
                se = 1'b0;
            end
            LOAD = (idx == busy_at) || (busy_at == -2 && $urandom_range(3, 0) == 0);
            DATA = ~data;
            SHIFT_EN = se;
            sbit = SER_DATA;
            tick();
            LOAD = 1'b0;
            if (se) begin
                if (idx < W) rx = {rx[W-2:0], sbit};
                idx++;
            end
            cyc++;
            if (cyc > 4 * FL + 20) begin
                check("frame_timeout", 1'b1, 1'b0);
                break;
            end
        end
        SHIFT_EN = 1'($urandom_range(1, 0));
        check("end_done", DONE, 1'b1);
        check("end_ready", READY, 1'b1);
        check("end_ser_en", SER_EN, 1'b0);
        check("end_ser_data", SER_DATA, 1'b0);
        check_word("rx_word", rx, data);
    endtask

    vec_t tbl [8];

    initial begin
        logic [W-1:0] rd;
        tbl[0] = '{8'hA5, 8'b1010_0101, 1'b0, -1, -1};
        tbl[1] = '{8'h81, 8'b1000_0001, 1'b0,  1, -1};
        tbl[2] = '{8'hC3, 8'b1100_0011, 1'b0, -1,  4};
        tbl[3] = '{8'h07, 8'b0000_0111, 1'b1, -1, -1};
        tbl[4] = '{8'h03, 8'b0000_0011, 1'b0, -1, -1};
        tbl[5] = '{8'h3C, 8'b0011_1100, 1'b0, -1, -1};
        tbl[6] = '{8'h80, 8'b1000_0000, 1'b1, -1, -1};
        tbl[7] = '{8'h7F, 8'b0111_1111, 1'b1,  6,  2};

        RST = 1'b0; LOAD = 1'b1; DATA = 8'hFF; SHIFT_EN = 1'b1;
        tick();
        check("rst_ready", READY, 1'b1);
        check("rst_ser_en", SER_EN, 1'b0);
        check("rst_ser_data", SER_DATA, 1'b0);
        check("rst_done", DONE, 1'b0);
        RST = 1'b1; LOAD = 1'b0;
        idle_check();

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].data, tbl[i].exp_bits, tbl[i].exp_par, 0,
                       tbl[i].stall_at, tbl[i].busy_at, -1);
            idle_check();
        end

        // Back-to-back: second load lands in the DONE cycle of the first frame.
        send_frame(8'hFF, 8'b1111_1111, 1'b0, 0, -1, -1, -1);
        send_frame(8'h00, 8'b0000_0000, 1'b0, 0, -1, -1, -1);
        idle_check();

        // Reset while bit 5 is on the wire.
        send_frame(8'h5A, 8'b0101_1010, 1'b0, 0, -1, -1, 5);
        idle_check();

        for (int n = 0; n < 20; n++) begin
            rd = W'($urandom);
            send_frame(rd, rd, ^rd, 30, -1, -2, -1);
            if ($urandom_range(1, 0) == 1) idle_check();
        end
        idle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
